// File: rtl/mantis_round_ctrl.sv
// Round sequencer for the MANTIS tweakable block cipher datapath: forward rounds,
// a middle reflection, then backward rounds, with a ready/valid handshake on each side.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// FWD   | forward rounds, round_idx counts up 0..ROUNDS-1
// MID   | middle reflection, single cycle
// BWD   | backward rounds, round_idx counts down ROUNDS-1..0
// DONE  | result held in state register until the consumer takes it
module mantis_round_ctrl #(
  parameter int ROUNDS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_decrypt,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       state_load,
  output logic       state_en,
  output logic [1:0] round_sel,
  output logic [3:0] round_idx,
  output logic       tweak_en,
  output logic       tweak_dir,
  output logic       dec_mode,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_MID  = 3'd2,
    S_BWD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      dec_mode <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) dec_mode <= in_decrypt;
    end
  end

  // The counter saturates at each end of a pass, so round_idx never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = S_FWD;
          cnt_nx   = 4'd0;
        end
      end
      S_FWD: begin
        if (cnt == LAST) state_nx = S_MID;
        else             cnt_nx   = cnt + 4'd1;
      end
      S_MID: begin
        state_nx = S_BWD;
        cnt_nx   = LAST;
      end
      S_BWD: begin
        if (cnt == 4'd0) state_nx = S_DONE;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = S_FWD;
            cnt_nx   = 4'd0;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    state_load = 1'b0;
    state_en   = 1'b0;
    round_sel  = 2'd0;
    round_idx  = 4'd0;
    tweak_en   = 1'b0;
    tweak_dir  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready   = 1'b1;
        state_load = in_valid;
      end
      S_FWD: begin
        state_en  = 1'b1;
        tweak_en  = 1'b1;
        round_idx = cnt;
        busy      = 1'b1;
      end
      S_MID: begin
        state_en  = 1'b1;
        round_sel = 2'd1;
        busy      = 1'b1;
      end
      S_BWD: begin
        state_en  = 1'b1;
        tweak_en  = 1'b1;
        tweak_dir = 1'b1;
        round_sel = 2'd2;
        round_idx = cnt;
        busy      = 1'b1;
      end
      S_DONE: begin
        out_valid  = 1'b1;
        in_ready   = out_ready;
        state_load = out_ready & in_valid;
      end
      default: ;
    endcase
  end

endmodule
